// File: rtl/tlb_op_ctrl_pkg.sv
// Shared encodings for the TLB management-op sequencer: op codes, INVTLB ops and FSM states.
package tlb_op_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } op_code_e;

  localparam logic [4:0] INV_ALL0        = 5'd0;
  localparam logic [4:0] INV_ALL1        = 5'd1;
  localparam logic [4:0] INV_GLOBAL      = 5'd2;
  localparam logic [4:0] INV_NONGLOBAL   = 5'd3;
  localparam logic [4:0] INV_ASID        = 5'd4;
  localparam logic [4:0] INV_ASID_VA     = 5'd5;
  localparam logic [4:0] INV_GLOBAL_ASID = 5'd6;

  localparam logic [5:0] PS_HUGE = 6'd21;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SRCH,
    S_SRCH_WB,
    S_RD,
    S_RD_WB,
    S_WR,
    S_INV_RD,
    S_INV_CHK,
    S_DONE
  } state_e;

endpackage

// File: rtl/tlb_op_ctrl_inv_match.sv
// Combinational INVTLB entry-match: decides whether one read-back entry is hit by the given INVTLB op.
module tlb_inv_match
  import tlb_op_ctrl_pkg::*;
(
  input  logic [4:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [18:0] inv_vppn,
  input  logic        ent_e,
  input  logic        ent_g,
  input  logic [9:0]  ent_asid,
  input  logic [18:0] ent_vppn,
  input  logic [5:0]  ent_ps,
  output logic        match
);

  logic va_eq;
  logic asid_eq;
  logic sel;

  // Huge pages cover 2^9 small-page VPPNs, so only the upper VPPN bits are significant.
  always_comb begin
    va_eq   = (ent_ps == PS_HUGE) ? (ent_vppn[18:9] == inv_vppn[18:9])
                                  : (ent_vppn == inv_vppn);
    asid_eq = (ent_asid == inv_asid);
    case (inv_op)
      INV_ALL0, INV_ALL1: sel = 1'b1;
      INV_GLOBAL:         sel = ent_g;
      INV_NONGLOBAL:      sel = ~ent_g;
      INV_ASID:           sel = ~ent_g & asid_eq;
      INV_ASID_VA:        sel = ~ent_g & asid_eq & va_eq;
      INV_GLOBAL_ASID:    sel = (ent_g | asid_eq) & va_eq;
      default:            sel = 1'b0;
    endcase
    match = ent_e & sel;
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Multi-cycle sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: drives the TLB array ports,
// raises the CSR update strobes and holds commit until the op completes.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter int TLB_NUM = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_vppn,
  input  logic [IDX_W-1:0] csr_index,
  output logic             op_done,
  output logic             op_err,
  output logic             tlb_srch_en,
  input  logic             tlb_srch_hit,
  input  logic [IDX_W-1:0] tlb_srch_idx,
  output logic             tlb_rd_en,
  output logic [IDX_W-1:0] tlb_rd_idx,
  input  logic             tlb_rd_e,
  input  logic             tlb_rd_g,
  input  logic [9:0]       tlb_rd_asid,
  input  logic [18:0]      tlb_rd_vppn,
  input  logic [5:0]       tlb_rd_ps,
  output logic             tlb_we,
  output logic             tlb_inv_we,
  output logic [IDX_W-1:0] tlb_w_idx,
  output logic             tlbrd_en,
  output logic             tlbsrch_we,
  output logic             tlbsrch_ne,
  output logic [IDX_W-1:0] tlbsrch_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_NUM - 1);

  state_e           state;
  logic [4:0]       inv_op_q;
  logic [9:0]       inv_asid_q;
  logic [18:0]      inv_vppn_q;
  logic [IDX_W-1:0] scan;
  logic [IDX_W-1:0] rand_idx;
  logic             inv_hit;

  tlb_inv_match u_inv_match (
    .inv_op   (inv_op_q),
    .inv_asid (inv_asid_q),
    .inv_vppn (inv_vppn_q),
    .ent_e    (tlb_rd_e),
    .ent_g    (tlb_rd_g),
    .ent_asid (tlb_rd_asid),
    .ent_vppn (tlb_rd_vppn),
    .ent_ps   (tlb_rd_ps),
    .match    (inv_hit)
  );

  // The array's search/read results only become valid in the cycle after the request,
  // so the fields that depend on them are qualified by state rather than registered.
  assign tlbsrch_ne  = (state == S_SRCH_WB) & ~tlb_srch_hit;
  assign tlbsrch_idx = ((state == S_SRCH_WB) && tlb_srch_hit) ? tlb_srch_idx : '0;
  assign tlb_inv_we  = (state == S_INV_CHK) & inv_hit;

  // Free-running victim pointer for TLBFILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rand_idx <= '0;
    end else begin
      rand_idx <= (rand_idx == LAST_IDX) ? '0 : rand_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_ready    <= 1'b1;
      op_done     <= 1'b0;
      op_err      <= 1'b0;
      tlb_srch_en <= 1'b0;
      tlb_rd_en   <= 1'b0;
      tlb_rd_idx  <= '0;
      tlb_we      <= 1'b0;
      tlb_w_idx   <= '0;
      tlbrd_en    <= 1'b0;
      tlbsrch_we  <= 1'b0;
      inv_op_q    <= '0;
      inv_asid_q  <= '0;
      inv_vppn_q  <= '0;
      scan        <= '0;
    end else begin
      op_done     <= 1'b0;
      op_err      <= 1'b0;
      tlb_srch_en <= 1'b0;
      tlb_rd_en   <= 1'b0;
      tlb_we      <= 1'b0;
      tlbrd_en    <= 1'b0;
      tlbsrch_we  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_ready   <= 1'b0;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_vppn;
            case (op_code)
              OP_SRCH: begin
                state       <= S_SRCH;
                tlb_srch_en <= 1'b1;
              end
              OP_RD: begin
                state      <= S_RD;
                tlb_rd_en  <= 1'b1;
                tlb_rd_idx <= csr_index;
              end
              OP_WR: begin
                state     <= S_WR;
                tlb_we    <= 1'b1;
                op_done   <= 1'b1;
                tlb_w_idx <= csr_index;
              end
              OP_FILL: begin
                state     <= S_WR;
                tlb_we    <= 1'b1;
                op_done   <= 1'b1;
                tlb_w_idx <= rand_idx;
              end
              OP_INV: begin
                if (inv_op > INV_GLOBAL_ASID) begin
                  state   <= S_DONE;
                  op_done <= 1'b1;
                  op_err  <= 1'b1;
                end else begin
                  state      <= S_INV_RD;
                  tlb_rd_en  <= 1'b1;
                  tlb_rd_idx <= scan;
                end
              end
              default: begin
                state   <= S_DONE;
                op_done <= 1'b1;
              end
            endcase
          end
        end
        S_SRCH: begin
          state      <= S_SRCH_WB;
          tlbsrch_we <= 1'b1;
          op_done    <= 1'b1;
        end
        S_RD: begin
          state    <= S_RD_WB;
          tlbrd_en <= 1'b1;
          op_done  <= 1'b1;
        end
        S_SRCH_WB, S_RD_WB, S_WR, S_DONE: begin
          state     <= S_IDLE;
          op_ready  <= 1'b1;
          tlb_w_idx <= '0;
        end
        S_INV_RD: begin
          state     <= S_INV_CHK;
          tlb_w_idx <= scan;
          if (scan == LAST_IDX) begin
            op_done <= 1'b1;
          end
        end
        S_INV_CHK: begin
          if (scan == LAST_IDX) begin
            state     <= S_IDLE;
            op_ready  <= 1'b1;
            scan      <= '0;
            tlb_w_idx <= '0;
          end else begin
            state      <= S_INV_RD;
            scan       <= scan + 1'b1;
            tlb_rd_en  <= 1'b1;
            tlb_rd_idx <= scan + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scoreboard bench for tlb_op_ctrl: a small TLB array model answers reads/searches, the driver
// queues expected completions, read indices and invalidations, and a monitor checks them as they appear.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  localparam int TLB_NUM = 16;
  localparam int IDX_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [2:0]       op_code = '0;
  logic [4:0]       inv_op = '0;
  logic [9:0]       inv_asid = '0;
  logic [18:0]      inv_vppn = '0;
  logic [IDX_W-1:0] csr_index = '0;
  logic             op_done, op_err;
  logic             tlb_srch_en;
  logic             tlb_srch_hit;
  logic [IDX_W-1:0] tlb_srch_idx;
  logic             tlb_rd_en;
  logic [IDX_W-1:0] tlb_rd_idx;
  logic             tlb_rd_e, tlb_rd_g;
  logic [9:0]       tlb_rd_asid;
  logic [18:0]      tlb_rd_vppn;
  logic [5:0]       tlb_rd_ps;
  logic             tlb_we, tlb_inv_we;
  logic [IDX_W-1:0] tlb_w_idx;
  logic             tlbrd_en, tlbsrch_we, tlbsrch_ne;
  logic [IDX_W-1:0] tlbsrch_idx;

  tlb_op_ctrl #(.TLB_NUM(TLB_NUM), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .csr_index(csr_index),
    .op_done(op_done), .op_err(op_err), .tlb_srch_en(tlb_srch_en), .tlb_srch_hit(tlb_srch_hit),
    .tlb_srch_idx(tlb_srch_idx), .tlb_rd_en(tlb_rd_en), .tlb_rd_idx(tlb_rd_idx),
    .tlb_rd_e(tlb_rd_e), .tlb_rd_g(tlb_rd_g), .tlb_rd_asid(tlb_rd_asid), .tlb_rd_vppn(tlb_rd_vppn),
    .tlb_rd_ps(tlb_rd_ps), .tlb_we(tlb_we), .tlb_inv_we(tlb_inv_we), .tlb_w_idx(tlb_w_idx),
    .tlbrd_en(tlbrd_en), .tlbsrch_we(tlbsrch_we), .tlbsrch_ne(tlbsrch_ne), .tlbsrch_idx(tlbsrch_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [12:0] fields;
    int unsigned due;
  } done_t;

  done_t            doneQ[$];
  logic [IDX_W-1:0] rdQ[$];
  logic [IDX_W-1:0] invQ[$];
  int               checks = 0;
  int               errors = 0;
  int unsigned      edgeCnt;

  logic             entE[TLB_NUM];
  logic             entG[TLB_NUM];
  logic [9:0]       entAsid[TLB_NUM];
  logic [18:0]      entVppn[TLB_NUM];
  logic [5:0]       entPs[TLB_NUM];
  logic             srchHitVal = 1'b0;
  logic [IDX_W-1:0] srchIdxVal = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [12:0] mkFields(input logic err, input logic swe, input logic ne,
                                           input logic [3:0] sidx, input logic we,
                                           input logic [3:0] widx, input logic rden);
    return {err, swe, ne, sidx, we, widx, rden};
  endfunction

  // Array model: registered read and search ports, plus an edge counter mirroring elapsed cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edgeCnt      <= 0;
      tlb_rd_e     <= 1'b0;
      tlb_rd_g     <= 1'b0;
      tlb_rd_asid  <= '0;
      tlb_rd_vppn  <= '0;
      tlb_rd_ps    <= '0;
      tlb_srch_hit <= 1'b0;
      tlb_srch_idx <= '0;
    end else begin
      edgeCnt <= edgeCnt + 1;
      if (tlb_rd_en) begin
        tlb_rd_e    <= entE[tlb_rd_idx];
        tlb_rd_g    <= entG[tlb_rd_idx];
        tlb_rd_asid <= entAsid[tlb_rd_idx];
        tlb_rd_vppn <= entVppn[tlb_rd_idx];
        tlb_rd_ps   <= entPs[tlb_rd_idx];
      end
      if (tlb_srch_en) begin
        tlb_srch_hit <= srchHitVal;
        tlb_srch_idx <= srchIdxVal;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a read, an invalidate or a completion.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("strobe_onehot", 32'($countones({tlb_we, tlb_inv_we, tlbrd_en, tlbsrch_we}) <= 1), 32'd1);
      if (tlb_rd_en) begin
        if (rdQ.size() == 0) checkOutput("unexpected_rd_en", 32'(tlb_rd_idx), 32'hFFFF);
        else checkOutput("rd_idx", 32'(tlb_rd_idx), 32'(rdQ.pop_front()));
      end
      if (tlb_inv_we) begin
        if (invQ.size() == 0) checkOutput("unexpected_inv_we", 32'(tlb_w_idx), 32'hFFFF);
        else checkOutput("inv_idx", 32'(tlb_w_idx), 32'(invQ.pop_front()));
      end
      if (op_done) begin
        if (doneQ.size() == 0) begin
          checkOutput("unexpected_done", 32'(edgeCnt), 32'hFFFF);
        end else begin
          done_t d;
          d = doneQ.pop_front();
          checkOutput({d.name, "_fields"},
                      32'(mkFields(op_err, tlbsrch_we, tlbsrch_ne, tlbsrch_idx, tlb_we,
                                   tlb_we ? tlb_w_idx : 4'd0, tlbrd_en)), 32'(d.fields));
          checkOutput({d.name, "_latency"}, edgeCnt, d.due);
          checkOutput({d.name, "_ready_low"}, 32'(op_ready), 32'd0);
        end
      end
    end
  end

  // Caller must be just past a negedge with the DUT idle; accept happens at the next posedge.
  task automatic applyStimulus(input string name, input logic [2:0] code, input logic [4:0] iop,
                               input logic [9:0] asid, input logic [18:0] vppn,
                               input logic [3:0] cidx, input int lat, input logic [12:0] expFields,
                               input bit holdValid);
    done_t d;
    int unsigned due;
    op_code   = code;
    inv_op    = iop;
    inv_asid  = asid;
    inv_vppn  = vppn;
    csr_index = cidx;
    op_valid  = 1'b1;
    due       = edgeCnt + lat;
    d.name    = name;
    d.fields  = expFields;
    d.due     = due;
    doneQ.push_back(d);
    @(posedge clk);
    #1;
    if (holdValid) begin
      op_code = OP_WR;
      @(posedge clk);
      #1;
    end
    op_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (op_ready) break;
    end
    checkOutput({name, "_ready_return"}, edgeCnt, due + 1);
  endtask

  initial begin
    for (int i = 0; i < TLB_NUM; i++) begin
      entE[i] = 1'b0; entG[i] = 1'b0; entAsid[i] = '0; entVppn[i] = '0; entPs[i] = 6'd12;
    end
    entE[2]  = 1'b1; entG[2]  = 1'b0; entAsid[2]  = 10'h12; entVppn[2]  = 19'h1000;
    entE[4]  = 1'b0; entG[4]  = 1'b1; entAsid[4]  = 10'h12; entVppn[4]  = 19'h1000;
    entE[7]  = 1'b1; entG[7]  = 1'b1; entAsid[7]  = 10'h12; entVppn[7]  = 19'h1000;
    entE[11] = 1'b1; entG[11] = 1'b1; entAsid[11] = 10'h20; entVppn[11] = 19'h1155; entPs[11] = 6'd21;
    entE[13] = 1'b1; entG[13] = 1'b0; entAsid[13] = 10'h12; entVppn[13] = 19'h1155;

    #12;
    checkOutput("reset_outputs",
                32'({op_ready, op_done, op_err, tlb_srch_en, tlb_rd_en, tlb_we, tlb_inv_we,
                     tlbrd_en, tlbsrch_we, tlbsrch_ne, tlbsrch_idx, tlb_rd_idx, tlb_w_idx}),
                32'({1'b1, 21'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    srchHitVal = 1'b1; srchIdxVal = 4'd5;
    applyStimulus("srch_hit", OP_SRCH, 5'd0, '0, '0, 4'd0, 2, mkFields(0, 1, 0, 4'd5, 0, 4'd0, 0), 1'b0);
    srchHitVal = 1'b0; srchIdxVal = 4'd6;
    applyStimulus("srch_miss", OP_SRCH, 5'd0, '0, '0, 4'd0, 2, mkFields(0, 1, 1, 4'd0, 0, 4'd0, 0), 1'b0);

    rdQ.push_back(4'd9);
    applyStimulus("rd", OP_RD, 5'd0, '0, '0, 4'd9, 2, mkFields(0, 0, 0, 4'd0, 0, 4'd0, 1), 1'b1);

    applyStimulus("wr", OP_WR, 5'd0, '0, '0, 4'd3, 1, mkFields(0, 0, 0, 4'd0, 1, 4'd3, 0), 1'b0);

    for (int i = 0; i < TLB_NUM && (edgeCnt % TLB_NUM) != TLB_NUM - 1; i++) @(negedge clk);
    applyStimulus("fill", OP_FILL, 5'd0, '0, '0, 4'd3, 1, mkFields(0, 0, 0, 4'd0, 1, 4'd15, 0), 1'b0);

    applyStimulus("nop", 3'd5, 5'd0, '0, '0, 4'd0, 1, mkFields(0, 0, 0, 4'd0, 0, 4'd0, 0), 1'b0);
    applyStimulus("inv7", OP_INV, 5'd7, '0, '0, 4'd0, 1, mkFields(1, 0, 0, 4'd0, 0, 4'd0, 0), 1'b0);

    for (int i = 0; i < TLB_NUM; i++) rdQ.push_back(4'(i));
    invQ.push_back(4'd2);
    applyStimulus("inv5", OP_INV, 5'd5, 10'h12, 19'h1000, 4'd0, 32, mkFields(0, 0, 0, 4'd0, 0, 4'd0, 0), 1'b0);

    for (int i = 0; i < TLB_NUM; i++) rdQ.push_back(4'(i));
    invQ.push_back(4'd2); invQ.push_back(4'd7); invQ.push_back(4'd11);
    applyStimulus("inv6", OP_INV, 5'd6, 10'h12, 19'h1000, 4'd0, 32, mkFields(0, 0, 0, 4'd0, 0, 4'd0, 0), 1'b0);

    for (int i = 0; i < TLB_NUM; i++) rdQ.push_back(4'(i));
    invQ.push_back(4'd2); invQ.push_back(4'd13);
    applyStimulus("inv3", OP_INV, 5'd3, 10'h0, 19'h0, 4'd0, 32, mkFields(0, 0, 0, 4'd0, 0, 4'd0, 0), 1'b0);

    checkOutput("queues_drained_pre_reset", 32'(doneQ.size() + rdQ.size() + invQ.size()), 32'd0);

    // INVTLB op0 cut short by reset part-way through the scan.
    for (int i = 0; i < TLB_NUM; i++) rdQ.push_back(4'(i));
    invQ.push_back(4'd2); invQ.push_back(4'd7); invQ.push_back(4'd11); invQ.push_back(4'd13);
    op_code = OP_INV; inv_op = 5'd0; op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_scan",
                32'({op_ready, op_done, op_err, tlb_srch_en, tlb_rd_en, tlb_we, tlb_inv_we,
                     tlbrd_en, tlbsrch_we, tlbsrch_ne}), 32'(10'b10_0000_0000));
    doneQ.delete(); rdQ.delete(); invQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    srchHitVal = 1'b1; srchIdxVal = 4'd12;
    applyStimulus("srch_after_reset", OP_SRCH, 5'd0, '0, '0, 4'd0, 2,
                  mkFields(0, 1, 0, 4'd12, 0, 4'd0, 0), 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queues_drained", 32'(doneQ.size() + rdQ.size() + invQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/tlb_op_ctrl.md
Name: tlb_op_ctrl

Overview:
Multi-cycle sequencer for the LoongArch32 TLB management instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB, issued from the commit stage.
- Drives the TLB array's registered read, search and write ports.
- Generates the CSR update strobes. tlbrd_en loads TLBEHI/TLBELO0/TLBELO1/ASID/TLBIDX; tlbsrch_we updates TLBIDX.
- Holds commit (op_ready=0) until the operation completes.

Parameters:
TLB_NUM, 16, number of TLB entries (power of two)
IDX_W, 4, log2(TLB_NUM)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
op_valid  in  1  TLB op request from commit
op_ready  out  1  high only in IDLE
op_code  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV, others=NOP
inv_op  in  5  INVTLB op field
inv_asid  in  10  rj[9:0]
inv_vppn  in  19  rk[31:13]
csr_index  in  IDX_W  TLBIDX.index
op_done  out  1  one-cycle completion pulse
op_err  out  1  pulse with op_done: INVTLB op>6 (INE)
tlb_srch_en  out  1  search request; array result valid next cycle
tlb_srch_hit  in  1  search hit
tlb_srch_idx  in  IDX_W  hit index
tlb_rd_en  out  1  read request; data valid next cycle
tlb_rd_idx  out  IDX_W  read index
tlb_rd_e, tlb_rd_g  in  1 each  entry E and G bits
tlb_rd_asid  in  10  entry ASID
tlb_rd_vppn  in  19  entry VPPN
tlb_rd_ps  in  6  entry page size (12 or 21)
tlb_we  out  1  full-entry write from CSRs
tlb_inv_we  out  1  clear E of entry tlb_w_idx
tlb_w_idx  out  IDX_W  write index
tlbrd_en  out  1  load CSRs from read data
tlbsrch_we  out  1  update TLBIDX
tlbsrch_ne  out  1  NE value (1 = miss)
tlbsrch_idx  out  IDX_W  index value

Behaviour:
- Reset values: all outputs 0 except op_ready=1; state=IDLE; scan counter=0; rand counter=0.
- Accept: op_valid && op_ready at edge E0. op_code, inv_op, inv_asid, inv_vppn and csr_index are latched at E0. op_valid while busy is ignored.
- States: IDLE, SRCH, SRCH_WB, RD, RD_WB, WR, INV_RD, INV_CHK, DONE.
- SRCH:
  - tlb_srch_en=1, then SRCH_WB.
  - SRCH_WB: tlbsrch_we=1, tlbsrch_ne=~hit, tlbsrch_idx=hit?idx:0. op_done=1, then IDLE (2 cycles).
- RD:
  - tlb_rd_en=1 with the latched index, then RD_WB.
  - RD_WB: tlbrd_en=1, op_done=1, then IDLE (2 cycles).
- WR/FILL:
  - WR: tlb_we=1, op_done=1, then IDLE (1 cycle).
  - Index is the latched csr_index for WR, or rand_idx sampled at E0 for FILL.
- rand_idx: free-running counter, +1 every cycle, wraps TLB_NUM-1 -> 0.
- INVTLB with inv_op>6: DONE with op_done=1, op_err=1, no array access.
- INVTLB with inv_op<=6: scan idx 0..TLB_NUM-1, 2 cycles per entry.
  - INV_RD: tlb_rd_en=1, tlb_rd_idx=scan.
  - INV_CHK: tlb_inv_we=1 with tlb_w_idx=scan if the entry matches.
    - Entries with E=0 never match.
    - va_eq = vppn compare; when ps==21, compare bits [18:9] only.
    - asid_eq = (tlb_rd_asid==inv_asid).
    - op0/1: match all.
    - op2: G=1.
    - op3: G=0.
    - op4: G=0 & asid_eq.
    - op5: G=0 & asid_eq & va_eq.
    - op6: (G=1 | asid_eq) & va_eq.
  - INV_CHK with scan==TLB_NUM-1: op_done=1 in that cycle, scan<=0, then IDLE. Total 2*TLB_NUM cycles.
- NOP op_code (5..7): DONE, op_done=1.
- op_done is exactly one cycle per accepted op. op_ready is low from E0+1 through the op_done cycle.
- At most one of tlb_we / tlb_inv_we / tlbrd_en / tlbsrch_we is high in any cycle.
- Async reset mid-operation returns to IDLE immediately and drops every strobe. The partially completed INVTLB is not resumed.

Decomposition:
- Shared package: op_code encodings, INVTLB op encodings, state enum, PS_HUGE=21.
- One natural sub-module, tlb_inv_match: combinational entry-match function for INVTLB.

Test Plan:
- TLBSRCH with hit=1, idx=5 -> tlbsrch_we at accept+2, ne=0, idx=5, op_done same cycle. With hit=0 -> ne=1, idx=0.
- TLBRD with csr_index=9 -> tlb_rd_en with idx=9 at accept+1; tlbrd_en and op_done at accept+2; op_ready=1 at accept+3.
- TLBFILL accepted when rand counter=15 -> tlb_we with w_idx=15 at accept+1.
- TLBWR with csr_index=3 -> tlb_we with w_idx=3 at accept+1.
- INVTLB op5, asid=0x12, vppn=0x1000; entries: 2 (G=0, ASID 0x12, VPPN 0x1000), 7 (G=1, same ASID/VPPN), 11 (ps=21, VPPN 0x1155) -> only entry 2 invalidated. op_done after 32 cycles.
- INVTLB op7 -> op_done and op_err at accept+1, no array strobes. Reset asserted during an INVTLB scan -> op_ready=1 and all strobes 0 immediately.
